// File: rtl/fp_align_shifter.sv
// ---------------------------------------------------------------------------
// fp_align_shifter
//
// Exponent-alignment front end for a single-precision floating-point adder.
// Accepts an IEEE-754 operand pair, orders the operands by magnitude
// (effective exponent first, then mantissa), then right-shifts the smaller
// mantissa one bit per cycle until it lines up with the larger one. The shift
// is capped at SHIFT_CAP positions. Bits shifted out are folded into a sticky
// bit so a later rounding stage still sees them.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   in_valid    operand pair valid
//   in_ready    block can accept an operand pair (IDLE only)
//   a, b        IEEE-754 single-precision operands
//   out_valid   aligned result valid (DONE only)
//   out_ready   downstream accepts the result
//   exp_out     effective exponent of the larger operand
//   big_mant    larger operand mantissa, hidden bit included (24 bits)
//   small_mant  smaller operand mantissa plus guard/round/sticky:
//               [26:3] mantissa, [2] guard, [1] round, [0] sticky
//   sign_big    sign of the larger operand
//   sign_small  sign of the smaller operand
//   swap        1 when b was chosen as the larger operand
//   special     1 when either operand has exponent 0xFF (Inf/NaN)
// ---------------------------------------------------------------------------
module fp_align_shifter #(
  parameter int SHIFT_CAP = 27
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  exp_out,
  output logic [23:0] big_mant,
  output logic [26:0] small_mant,
  output logic        sign_big,
  output logic        sign_small,
  output logic        swap,
  output logic        special
);

  localparam int CW = $clog2(SHIFT_CAP + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t       state, state_nxt;
  logic [CW-1:0] cnt;

  // -------------------------------------------------------------------------
  // Operand decode and ordering, evaluated only for the acceptance cycle.
  // -------------------------------------------------------------------------
  logic          accept;
  logic [7:0]    exp_a_eff, exp_b_eff;
  logic [23:0]   mant_a, mant_b;
  logic          b_big;
  logic [7:0]    exp_diff;
  logic [CW-1:0] acc_cnt;
  logic          acc_special;

  assign accept = in_valid && (state == IDLE);

  always_comb begin
    // NOTE: every variable written here gets a default first so no path
    // leaves one unassigned, which would otherwise infer a latch.
    exp_a_eff   = a[30:23];
    exp_b_eff   = b[30:23];
    mant_a      = {1'b1, a[22:0]};
    mant_b      = {1'b1, b[22:0]};
    b_big       = 1'b0;
    exp_diff    = 8'd0;
    acc_cnt     = '0;
    acc_special = 1'b0;

    // Zero/denormal operands: hidden bit 0, effective exponent 1.
    if (a[30:23] == 8'd0) begin
      exp_a_eff = 8'd1;
      mant_a    = {1'b0, a[22:0]};
    end
    if (b[30:23] == 8'd0) begin
      exp_b_eff = 8'd1;
      mant_b    = {1'b0, b[22:0]};
    end

    // A full tie keeps a as the big operand.
    b_big = (exp_b_eff > exp_a_eff) ||
            ((exp_b_eff == exp_a_eff) && (mant_b > mant_a));

    exp_diff = b_big ? (exp_b_eff - exp_a_eff) : (exp_a_eff - exp_b_eff);

    if (32'(exp_diff) > SHIFT_CAP) acc_cnt = CW'(SHIFT_CAP);
    else                           acc_cnt = CW'(exp_diff);

    acc_special = (a[30:23] == 8'hFF) || (b[30:23] == 8'hFF);
  end

  // -------------------------------------------------------------------------
  // Control FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          // Special operands bypass alignment and keep small_mant unshifted.
          if ((acc_cnt == '0) || acc_special) state_nxt = DONE;
          else                                state_nxt = ALIGN;
        end
      end
      ALIGN: begin
        // This edge takes cnt from 1 to 0, completing the alignment.
        if (cnt == CW'(1)) state_nxt = DONE;
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake flags come straight from the state so in_ready cannot rise in
  // the same cycle as the output handoff.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      exp_out    <= 8'd0;
      big_mant   <= 24'd0;
      small_mant <= 27'd0;
      sign_big   <= 1'b0;
      sign_small <= 1'b0;
      swap       <= 1'b0;
      special    <= 1'b0;
      cnt        <= '0;
    end else if (accept) begin
      swap       <= b_big;
      special    <= acc_special;
      cnt        <= acc_cnt;
      if (b_big) begin
        exp_out    <= exp_b_eff;
        big_mant   <= mant_b;
        small_mant <= {mant_a, 3'b000};
        sign_big   <= b[31];
        sign_small <= a[31];
      end else begin
        exp_out    <= exp_a_eff;
        big_mant   <= mant_a;
        small_mant <= {mant_b, 3'b000};
        sign_big   <= a[31];
        sign_small <= b[31];
      end
    end else if (state == ALIGN) begin
      // Shift right by one; the bit leaving position 1 is ORed into sticky.
      small_mant <= {1'b0, small_mant[26:2], small_mant[1] | small_mant[0]};
      cnt        <= cnt - CW'(1);
    end
  end

endmodule

// File: tb/tb_fp_align_shifter.sv
// ---------------------------------------------------------------------------
// tb_fp_align_shifter
//
// Self-checking bench for fp_align_shifter. Directed vectors cover the
// documented corner cases (equal operands, swap, guard/sticky, capped shift,
// special operands with output back-pressure, reset mid-alignment), followed
// by randomized operand pairs checked against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_fp_align_shifter;

  localparam int CAP     = 27;
  localparam int LAT_MAX = 100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  exp_out;
  logic [23:0] big_mant;
  logic [26:0] small_mant;
  logic        sign_big, sign_small, swap, special;

  int n_tests = 0;
  int n_fail  = 0;

  fp_align_shifter #(.SHIFT_CAP(CAP)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .exp_out    (exp_out),
    .big_mant   (big_mant),
    .small_mant (small_mant),
    .sign_big   (sign_big),
    .sign_small (sign_small),
    .swap       (swap),
    .special    (special)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: operands are ranked by the integer key
  // effective_exponent * 2^24 + mantissa, and the alignment is a single
  // arithmetic right shift whose discarded bits collapse into bit 0.
  typedef struct {
    int unsigned e;
    int unsigned bm;
    int unsigned sm;
    bit          sb;
    bit          ss;
    bit          sw;
    bit          sp;
    int          lat;
  } model_t;

  function automatic model_t model(input logic [31:0] x, input logic [31:0] y);
    model_t      r;
    int unsigned ex, ey, mx, my, es, ms, s, lost;
    int          k;
    ex = (x[30:23] == 0) ? 1 : int'(x[30:23]);
    ey = (y[30:23] == 0) ? 1 : int'(y[30:23]);
    mx = int'(x[22:0]) + ((x[30:23] != 0) ? (1 << 23) : 0);
    my = int'(y[22:0]) + ((y[30:23] != 0) ? (1 << 23) : 0);
    r.sw = ((ey << 24) + my) > ((ex << 24) + mx);
    if (r.sw) begin
      r.e = ey; r.bm = my; es = ex; ms = mx; r.sb = y[31]; r.ss = x[31];
    end else begin
      r.e = ex; r.bm = mx; es = ey; ms = my; r.sb = x[31]; r.ss = y[31];
    end
    r.sp = (x[30:23] == 8'hFF) || (y[30:23] == 8'hFF);
    k = int'(r.e - es);
    if (k > CAP) k = CAP;
    if (r.sp) k = 0;
    s    = ms * 8;
    lost = s % (1 << k);
    r.sm = (s >> k) | ((lost != 0) ? 1 : 0);
    r.lat = k + 1;
    return r;
  endfunction

  task automatic check_outputs(input string tag, input model_t m);
    check({tag, ".exp"},   32'(exp_out),    m.e);
    check({tag, ".big"},   32'(big_mant),   m.bm);
    check({tag, ".small"}, 32'(small_mant), m.sm);
    check({tag, ".sgn"},   {29'd0, sign_big, sign_small, swap},
                           {29'd0, m.sb, m.ss, m.sw});
    check({tag, ".spec"},  32'(special),    32'(m.sp));
  endtask

  // Runs one operand pair through the block. Junk is driven on a/b/in_valid
  // while the block is busy; the result is held for 'stall' cycles of
  // back-pressure before the handoff.
  task automatic do_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                       input int stall);
    model_t m;
    int     lat;
    int     waited;
    m = model(ta, tb_v);
    @(negedge clk);
    waited = 0;
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check({tag, ".rdy"}, 32'(in_ready), 32'd1);
    a = ta; b = tb_v; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    lat = 1;
    while (!out_valid && lat < LAT_MAX) begin
      check({tag, ".busy_rdy"}, 32'(in_ready), 32'd0);
      a = $urandom; b = $urandom; in_valid = 1'($urandom);
      @(negedge clk);
      lat++;
    end
    check({tag, ".lat"}, lat, m.lat);
    check_outputs(tag, m);
    for (int i = 0; i < stall; i++) begin
      a = $urandom; b = $urandom; in_valid = (i % 2 == 0);
      @(negedge clk);
      check({tag, ".hold_v"}, {30'd0, out_valid, in_ready}, 32'b10);
      check_outputs({tag, ".hold"}, m);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    check({tag, ".ho_rdy"}, 32'(in_ready), 32'd0);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, ".after_ho"}, {30'd0, out_valid, in_ready}, 32'b01);
  endtask

  function automatic logic [31:0] rand_operand(input int unsigned e);
    logic [31:0] v;
    v = $urandom;
    v[30:23] = e[7:0];
    return v;
  endfunction

  initial begin
    int unsigned ea, eb;
    int          mode;
    logic [31:0] ra, rb;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    #12;
    check("rst.flags", {30'd0, out_valid, in_ready}, 32'b01);
    check("rst.data", {exp_out, big_mant}, 32'd0);
    check("rst.small", 32'(small_mant), 32'd0);
    check("rst.bits", {28'd0, sign_big, sign_small, swap, special}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed corner cases.
    do_op("eq",     32'h3F80_0000, 32'h3F80_0000, 0);
    check("eq.abs_small", 32'(small_mant), 32'h400_0000);
    do_op("swap",   32'h3F80_0000, 32'h4040_0000, 2);
    check("swap.abs_big", 32'(big_mant), 32'hC0_0000);
    do_op("grs",    32'h4B80_0000, 32'h3F80_0001, 1);
    check("grs.abs_small", 32'(small_mant), 32'h5);
    do_op("cap",    32'h7F00_0000, 32'h0000_0001, 0);
    check("cap.abs_small", 32'(small_mant), 32'h1);
    do_op("inf",    32'h7F80_0000, 32'h3F80_0001, 5);
    do_op("nan_b",  32'h3F80_0000, 32'hFFC0_0000, 3);
    do_op("tie",    32'hBF80_0000, 32'h3F80_0000, 0);
    do_op("denorm", 32'h0000_0010, 32'h0080_0000, 0);

    // Reset asserted mid-alignment aborts the operation.
    @(negedge clk);
    a = 32'h4B80_0000; b = 32'h3F80_0001; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort.flags", {30'd0, out_valid, in_ready}, 32'b01);
    check("abort.data", {exp_out, big_mant}, 32'd0);
    check("abort.small", 32'(small_mant), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("abort.no_valid", 32'(out_valid), 32'd0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      check("abort.idle", {30'd0, out_valid, in_ready}, 32'b01);
    end
    do_op("reissue", 32'h4B80_0000, 32'h3F80_0001, 0);

    // Randomized pairs, biased toward small exponent gaps and edge exponents.
    for (int i = 0; i < 300; i++) begin
      mode = $urandom_range(0, 5);
      ea = $urandom_range(0, 255);
      case (mode)
        0: eb = $urandom_range(0, 255);
        1: eb = ea;
        2: eb = (ea + $urandom_range(0, 8)) % 256;
        3: eb = (ea > 30) ? ea - $urandom_range(20, 30) : ea + $urandom_range(20, 30);
        4: begin ea = $urandom_range(0, 1); eb = $urandom_range(0, 2); end
        default: eb = ($urandom_range(0, 3) == 0) ? 255 : $urandom_range(0, 255);
      endcase
      ra = rand_operand(ea);
      rb = rand_operand(eb);
      if (mode == 1 && $urandom_range(0, 3) == 0) rb[22:0] = ra[22:0];
      do_op($sformatf("rnd%0d", i), ra, rb, $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
